video_fade_core: RTL and testbench
==================================

VIDEO_FADE_CORE -- requirements
Module: video_fade_core

Interface
REQ-001 The block SHALL take parameter RSIZE, default 4, the red channel width.
REQ-002 The block SHALL take parameter GSIZE, default 4, the green channel width.
REQ-003 The block SHALL take parameter BSIZE, default 4, the blue channel width.
REQ-004 The block SHALL take parameter RGB_SIZE, default 12, the packed pixel width {r,g,b}, which equals RSIZE+GSIZE+BSIZE.
REQ-005 The block SHALL have these ports:
- clk  input  1  system clock; one clock; reset is asynchronous and active-low.
- rst  input  1  asynchronous reset, asserted when 0.
- avs_address  input  1  register select.
- avs_write  input  1  register write strobe.
- avs_writedata  input  32  register write data.
- src_fc  input  vga_fc_t  upstream frame counter: hc, vc, frame_start.
- src_vld  input  1  upstream pixel valid.
- src_rgb  input  RGB_SIZE  upstream pixel.
- src_rdy  output  1  ready to accept from upstream.
- snk_fc  output  vga_fc_t  downstream frame counter.
- snk_vld  output  1  downstream pixel valid.
- snk_rgb  output  RGB_SIZE  scaled pixel.
- snk_rdy  input  1  downstream ready.

Function
REQ-006 The block SHALL be a one-stage pipeline; an input transfer (src_vld&src_rdy) SHALL appear on snk_* on the next clk.
REQ-007 src_rdy SHALL equal snk_rdy | ~snk_vld, combinationally.
REQ-008 While snk_vld=1 and snk_rdy=0, snk_fc, snk_rgb and snk_vld SHALL hold.
REQ-009 snk_vld SHALL clear after a downstream transfer that has no simultaneous input transfer.
REQ-010 Register 0 (ctrl) SHALL decode writedata as:
- bit0: enable, sticky.
- bit1: start fade-in, pulse.
- bit2: start fade-out, pulse.
REQ-011 If bit1 and bit2 are written together, fade-out SHALL win.
REQ-012 Register 1 SHALL hold frames_per_step from writedata[7:0]; the value 0 SHALL behave as 1.
REQ-013 The block SHALL hold a 5-bit brightness level from 0 to 16.
REQ-014 For each channel c, out = (c*level)>>4; level 16 SHALL reproduce the input exactly and level 0 SHALL give 0.
REQ-015 When enable=0, snk_rgb SHALL equal the transferred src_rgb, with the same 1-cycle latency.
REQ-016 The FSM SHALL have three states:
- IDLE: level holds.
- FADE_IN: a ctrl bit1 write enters this state from any state.
- FADE_OUT: a ctrl bit2 write enters this state from any state.
REQ-017 A fade SHALL restart from the current level with frame_cnt cleared.
REQ-018 Level and frame_cnt SHALL advance only on an input transfer with src_fc.frame_start=1. The new level SHALL apply to that pixel and every later pixel.
REQ-019 In FADE_IN/FADE_OUT, frame_cnt SHALL increment per frame_start transfer. On reaching frames_per_step, it SHALL clear and level SHALL move by ±1.
REQ-020 When level reaches 16 in FADE_IN, or 0 in FADE_OUT, the FSM SHALL return to IDLE and level SHALL saturate with no wrap.
REQ-021 A fade-in start at level 16, or a fade-out start at level 0, SHALL complete at the next frame_start transfer.
REQ-022 A ctrl write in the same cycle as a frame_start transfer SHALL take priority; that frame SHALL not be counted.
REQ-023 Frame counting SHALL occur even when enable=0; scaling SHALL apply only when enable=1.

Reset
REQ-024 On rst=0, the block SHALL asynchronously set:
- snk_vld=0, snk_rgb=0, snk_fc all-zero.
- level=16, state=IDLE, frame_cnt=0.
- enable=0, frames_per_step=1.
REQ-025 Reset mid-fade or mid-stall SHALL discard the in-flight pixel and the fade state.

Configuration
REQ-026 With VIDEO_FADE_DONE_EN defined, the block SHALL add output port fade_done (1 bit, reset 0). fade_done SHALL pulse high for one clk on each FADE_IN/FADE_OUT→IDLE transition.
REQ-027 Without VIDEO_FADE_DONE_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package video_fade_pkg SHALL hold:
- LEVEL_W=5 and LEVEL_MAX=16.
- Register addresses REG_CTRL=0 and REG_FPS=1.
- The FSM state enum.
vga_fc_t SHALL stay in vga.svh.
REQ-029 A sub-module video_fade_scale (parameter width W, combinational c*level>>4) SHALL be instantiated once per channel.

Verification
REQ-030 Reset, then enable=1, then stream rgb=12'hF84 with snk_rdy=1 → snk_rgb=12'hF84 one cycle later; src_rdy=1 throughout.
REQ-031 fps=2, fade-out, 64 frames → level decrements every 2 frame_starts; after 32 frames, rgb 12'hF84 → 12'h000; IDLE; fade_done pulses once (VIDEO_FADE_DONE_EN defined).
REQ-032 Level=8, input 12'hF84 → output 12'h742.
REQ-033 Hold snk_rdy=0 for 5 cycles mid-line → src_rdy=0, snk outputs stable, no pixel lost or duplicated after release.
REQ-034 Write ctrl=3'b111 on a frame_start transfer cycle → FSM enters FADE_OUT, that frame is not counted, frame_cnt=0.
REQ-035 Assert rst=0 mid-fade at level 5 → level=16, IDLE, snk_vld=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/video_fade_pkg.sv
// video_fade_pkg: brightness constants, register map and FSM states for video_fade_core.
package video_fade_pkg;
`include "vga.svh"
   localparam int LEVEL_W = 5;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;
   localparam logic REG_CTRL = 1'b0;
   localparam logic REG_FPS  = 1'b1;
   typedef enum logic [1:0] {IDLE, FADE_IN, FADE_OUT} fade_state_e;
endpackage

// File: rtl/vga.svh
// vga.svh: VGA frame-counter sideband that travels alongside every pixel.
`ifndef VGA_SVH
`define VGA_SVH
typedef struct packed {
   logic [10:0] hc;
   logic [10:0] vc;
   logic        frame_start;
} vga_fc_t;
`endif

// File: rtl/video_fade_scale.sv
// video_fade_scale: combinational channel scaler, c * level / 16.
module video_fade_scale
   import video_fade_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0]       c_i,
   input  logic [LEVEL_W-1:0] level_i,
   output logic [W-1:0]       c_o
);
   logic [W+LEVEL_W-1:0] prod;
   logic                 unused_prod;
   assign prod        = c_i * level_i;
   // level never exceeds 16, so the product always fits back into W bits
   assign c_o         = prod[W+3:4];
   assign unused_prod = ^{prod[W+LEVEL_W-1], prod[3:0]};
endmodule

// File: rtl/video_fade_core.sv
// video_fade_core: one-stage RGB pipeline with register-controlled brightness fade.
// Define VIDEO_FADE_DONE_EN to add the fade_done completion pulse output.
module video_fade_core
   import video_fade_pkg::*;
#(
   parameter int RSIZE    = 4,
   parameter int GSIZE    = 4,
   parameter int BSIZE    = 4,
   parameter int RGB_SIZE = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                avs_address,
   input  logic                avs_write,
   input  logic [31:0]         avs_writedata,
   input  vga_fc_t             src_fc,
   input  logic                src_vld,
   input  logic [RGB_SIZE-1:0] src_rgb,
   output logic                src_rdy,
   output vga_fc_t             snk_fc,
   output logic                snk_vld,
   output logic [RGB_SIZE-1:0] snk_rgb,
   input  logic                snk_rdy
`ifdef VIDEO_FADE_DONE_EN
   ,output logic               fade_done
`endif
);
   fade_state_e          state_q, state_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic [7:0]           cnt_q, cnt_d, fps_q, fps_d, fps_eff;
   logic                 enable_q, enable_d, snk_vld_q, snk_vld_d;
   vga_fc_t              snk_fc_q, snk_fc_d;
   logic [RGB_SIZE-1:0]  snk_rgb_q, snk_rgb_d, scaled;
   logic                 wr_ctrl, wr_fps, in_xfer, tick, at_end, unused_wdata;
   assign wr_ctrl      = avs_write & (avs_address == REG_CTRL);
   assign wr_fps       = avs_write & (avs_address == REG_FPS);
   assign src_rdy      = snk_rdy | ~snk_vld_q;
   assign in_xfer      = src_vld & src_rdy;
   // a ctrl write wins over a simultaneous frame_start, which then goes uncounted
   assign tick         = in_xfer & src_fc.frame_start & ~wr_ctrl;
   assign fps_eff      = (fps_q == 8'd0) ? 8'd1 : fps_q;
   assign at_end       = (state_q == FADE_IN && level_q == LEVEL_MAX) || (state_q == FADE_OUT && level_q == '0);
   assign unused_wdata = ^avs_writedata[31:8];
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      if (wr_ctrl && (avs_writedata[2] || avs_writedata[1])) begin
         state_d = avs_writedata[2] ? FADE_OUT : FADE_IN;
         cnt_d   = '0;
      end else if (tick && state_q != IDLE) begin
         if (at_end) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else if (cnt_q + 8'd1 >= fps_eff) begin
            cnt_d   = '0;
            level_d = (state_q == FADE_IN) ? level_q + 5'd1 : level_q - 5'd1;
            state_d = (level_d == LEVEL_MAX || level_d == '0) ? IDLE : state_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end
   video_fade_scale #(.W(RSIZE)) u_r (.c_i(src_rgb[RGB_SIZE-1 -: RSIZE]), .level_i(level_d), .c_o(scaled[RGB_SIZE-1 -: RSIZE]));
   video_fade_scale #(.W(GSIZE)) u_g (.c_i(src_rgb[GSIZE+BSIZE-1 -: GSIZE]), .level_i(level_d), .c_o(scaled[GSIZE+BSIZE-1 -: GSIZE]));
   video_fade_scale #(.W(BSIZE)) u_b (.c_i(src_rgb[BSIZE-1:0]), .level_i(level_d), .c_o(scaled[BSIZE-1:0]));
   assign enable_d  = wr_ctrl ? avs_writedata[0] : enable_q;
   assign fps_d     = wr_fps ? avs_writedata[7:0] : fps_q;
   assign snk_vld_d = src_rdy ? src_vld : snk_vld_q;
   assign snk_fc_d  = in_xfer ? src_fc : snk_fc_q;
   assign snk_rgb_d = in_xfer ? (enable_q ? scaled : src_rgb) : snk_rgb_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         level_q   <= LEVEL_MAX;
         cnt_q     <= '0;
         enable_q  <= 1'b0;
         fps_q     <= 8'd1;
         snk_vld_q <= 1'b0;
         snk_fc_q  <= '0;
         snk_rgb_q <= '0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         enable_q  <= enable_d;
         fps_q     <= fps_d;
         snk_vld_q <= snk_vld_d;
         snk_fc_q  <= snk_fc_d;
         snk_rgb_q <= snk_rgb_d;
      end
   end
   assign snk_vld = snk_vld_q;
   assign snk_fc  = snk_fc_q;
   assign snk_rgb = snk_rgb_q;
`ifdef VIDEO_FADE_DONE_EN
   logic done_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) done_q <= 1'b0;
      else      done_q <= (state_q != IDLE) && (state_d == IDLE);
   end
   assign fade_done = done_q;
`endif
endmodule

// File: tb/tb_video_fade_core.sv
// tb_video_fade_core: scoreboard bench for video_fade_core with a reference brightness model.
module tb_video_fade_core;
   import video_fade_pkg::*;
   localparam int FCW = $bits(vga_fc_t);
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        avs_address, avs_write;
   logic [31:0] avs_writedata;
   vga_fc_t     src_fc, snk_fc;
   logic        src_vld, src_rdy, snk_vld, snk_rdy;
   logic [11:0] src_rgb, snk_rgb, last_rgb;
`ifdef VIDEO_FADE_DONE_EN
   logic        fade_done;
`endif
   int n_chk = 0, n_pass = 0;
   logic [FCW+11:0] sbq[$];
   int m_en, m_level, m_state, m_cnt, m_fps, m_done, done_seen;
   logic [10:0] vc = '0;
   always #5 clk = ~clk;
   video_fade_core dut (
      .clk(clk), .rst(rst), .avs_address(avs_address), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .src_fc(src_fc), .src_vld(src_vld), .src_rgb(src_rgb),
      .src_rdy(src_rdy), .snk_fc(snk_fc), .snk_vld(snk_vld), .snk_rgb(snk_rgb), .snk_rdy(snk_rdy)
`ifdef VIDEO_FADE_DONE_EN
      , .fade_done(fade_done)
`endif
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   function automatic logic [11:0] scale(input logic [11:0] p, input int l);
      logic [11:0] r;
      for (int k = 0; k < 3; k++) r[k*4 +: 4] = 4'((int'(p[k*4 +: 4]) * l) / 16);
      return r;
   endfunction
   task automatic model_reset();
      m_en = 0; m_level = 16; m_state = 0; m_cnt = 0; m_fps = 1;
      sbq.delete();
   endtask
   // state encoding in the model: 0 idle, 1 fading in, 2 fading out
   task automatic step(input logic v, input logic fs, input logic [11:0] rgb, input logic rdy,
                       input logic w, input logic a, input logic [31:0] d);
      logic exp_rdy, xfer, tick;
      @(negedge clk);
      src_vld = v; src_rgb = rgb; src_fc = '{hc: 11'($urandom), vc: vc, frame_start: fs};
      snk_rdy = rdy; avs_write = w; avs_address = a; avs_writedata = d;
      #1;
`ifdef VIDEO_FADE_DONE_EN
      if (fade_done) done_seen++;
`endif
      exp_rdy = rdy || (sbq.size() == 0);
      chk("snk_vld", snk_vld, sbq.size() != 0);
      chk("src_rdy", src_rdy, exp_rdy);
      if (snk_vld && sbq.size() != 0) begin
         chk("snk_data", {snk_fc, snk_rgb}, sbq[0]);
         if (rdy) begin
            last_rgb = snk_rgb;
            void'(sbq.pop_front());
         end
      end
      xfer = v && exp_rdy;
      tick = xfer && fs && !(w && !a);
      if (tick && m_state != 0) begin
         if ((m_state == 1 && m_level == 16) || (m_state == 2 && m_level == 0)) begin
            m_state = 0; m_cnt = 0; m_done++;
         end else begin
            m_cnt++;
            if (m_cnt >= ((m_fps == 0) ? 1 : m_fps)) begin
               m_cnt = 0;
               m_level += (m_state == 1) ? 1 : -1;
               if (m_level == 0 || m_level == 16) begin m_state = 0; m_done++; end
            end
         end
      end
      if (xfer) sbq.push_back({src_fc, (m_en != 0) ? scale(rgb, m_level) : rgb});
      if (w && !a) begin
         m_en = int'(d[0]);
         if (d[2]) begin m_state = 2; m_cnt = 0; end
         else if (d[1]) begin m_state = 1; m_cnt = 0; end
      end
      if (w && a) m_fps = int'(d[7:0]);
      if (fs) vc = vc + 11'd1;
   endtask
   task automatic px(input logic v, input logic fs, input logic [11:0] rgb, input logic rdy);
      step(v, fs, rgb, rdy, 1'b0, 1'b0, 32'd0);
   endtask
   task automatic wr(input logic a, input logic [31:0] d);
      step(1'b0, 1'b0, 12'd0, 1'b1, 1'b1, a, d);
   endtask
   initial begin
      model_reset(); m_done = 0; done_seen = 0; last_rgb = '0;
      src_vld = 0; src_rgb = 0; src_fc = '0; snk_rdy = 1; avs_write = 0; avs_address = 0; avs_writedata = 0;
      #12;
      chk("rst_vld", snk_vld, 0);
      chk("rst_rgb", snk_rgb, 0);
      chk("rst_fc", snk_fc, 0);
      chk("rst_rdy", src_rdy, 1);
      rst = 1;
      wr(1'b0, 32'd1);
      repeat (4) px(1, 0, 12'hF84, 1);
      px(0, 0, 0, 1);
      chk("pass_f84", last_rgb, 12'hF84);
      wr(1'b1, 32'd2);
      wr(1'b0, 32'd5);
      for (int i = 0; i < 40; i++) begin
         px(1, 1, 12'hF84, 1);
         px(1, 0, 12'($urandom), 1);
      end
      px(1, 0, 12'hF84, 1);
      px(0, 0, 0, 1);
      chk("fade_black", last_rgb, 12'h000);
`ifdef VIDEO_FADE_DONE_EN
      chk("done_once", done_seen, 1);
`endif
      wr(1'b1, 32'd0);
      wr(1'b0, 32'd3);
      repeat (8) px(1, 1, 12'hF84, 1);
      px(1, 0, 12'hF84, 1);
      px(0, 0, 0, 1);
      chk("lvl8", last_rgb, 12'h742);
      wr(1'b0, 32'd0);
      px(1, 0, 12'hF84, 1);
      px(0, 0, 0, 1);
      chk("bypass", last_rgb, 12'hF84);
      px(1, 1, 12'h123, 1);
      wr(1'b1, 32'd2);
      step(1, 1, 12'hF84, 1, 1, 1'b0, 32'd7);
      px(1, 1, 12'hF84, 1);
      px(0, 0, 0, 1);
      chk("ovr_nocount", last_rgb, 12'h842);
      px(1, 1, 12'hF84, 1);
      px(0, 0, 0, 1);
      chk("ovr_lvl8", last_rgb, 12'h742);
      for (int i = 0; i < 60; i++) px($urandom_range(3, 0) != 0, 0, 12'($urandom), $urandom_range(2, 0) != 0);
      px(1, 0, 12'hA5A, 1);
      repeat (5) px(1, 0, 12'($urandom), 0);
      px(0, 0, 0, 1);
      px(0, 0, 0, 1);
      wr(1'b1, 32'd1);
      repeat (3) px(1, 1, 12'hF84, 1);
      px(1, 0, 12'hF84, 0);
      px(1, 0, 12'h0F0, 0);
      @(negedge clk);
      src_vld = 0;
      #2 rst = 0;
      #1;
      chk("arst_vld", snk_vld, 0);
      chk("arst_rgb", snk_rgb, 0);
      chk("arst_rdy", src_rdy, 1);
      model_reset();
      @(negedge clk);
      rst = 1;
      wr(1'b0, 32'd1);
      px(1, 1, 12'hF84, 1);
      px(0, 0, 0, 1);
      chk("post_rst", last_rgb, 12'hF84);
      wr(1'b0, 32'd3);
      px(1, 1, 12'hF84, 1);
      px(1, 1, 12'hF84, 1);
      repeat (3) px(0, 0, 0, 1);
      chk("drained", sbq.size(), 0);
`ifdef VIDEO_FADE_DONE_EN
      chk("done_total", done_seen, m_done);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
